icache_controller: RTL and testbench
====================================

// Module: icache_controller
// PURPOSE
//  Direct-mapped, read-only instruction cache that responds to the PC fetch address
//  issued by the PC update logic each cycle. Returns INSTRUCTION same cycle on a hit.
//  On a miss it raises BUSYWAIT to stall PC update and refills one 128-bit block
//  from instruction memory via a MEM_READ/MEM_BUSYWAIT handshake.
// PARAMETERS
//  ADDR_WIDTH  10  PC bits used for lookup (PC[31:ADDR_WIDTH] ignored)
//  NUM_BLOCKS  8   cache lines; INDEX_BITS = log2(NUM_BLOCKS) = 3
//  (fixed: 16-byte block = 4 words; offset PC[3:2]; TAG_BITS = ADDR_WIDTH-4-INDEX_BITS = 3)
// PORTS
//  CLK           in   1    system clock, all state updates on posedge
//  RESET         in   1    synchronous, active-high
//  PC            in   32   fetch byte address (word aligned)
//  INSTRUCTION   out  32   fetched word; valid only when BUSYWAIT=0
//  BUSYWAIT      out  1    1 = stall PC/CPU; miss in progress
//  MEM_READ      out  1    block read request to instruction memory
//  MEM_ADDRESS   out  6    block address = {tag,index} (ADDR_WIDTH-4 bits)
//  MEM_READDATA  in   128  refill block; word0 = [31:0] ... word3 = [127:96]
//  MEM_BUSYWAIT  in   1    memory busy; data valid in cycle it deasserts while MEM_READ=1
// BEHAVIOUR
//  Storage: per line valid(1), tag(3), data(128). Index = PC[6:4], tag = PC[9:7].
//  Reset (RESET=1 at posedge): all valid bits cleared, state=IDLE, MEM_READ=0,
//   MEM_ADDRESS=0, latched miss tag/index=0. BUSYWAIT forced 0 while RESET=1.
//   Data array not cleared. Reset overrides any state, incl. mid-refill (MEM_READ drops next cycle).
//  Hit = valid[idx] && tag[idx]==PC tag. INSTRUCTION = data[idx] word PC[3:2], combinational.
//  FSM states:
//   IDLE  : hit -> BUSYWAIT=0, stay. miss -> BUSYWAIT=1 combinationally same cycle;
//           latch {tag,index}; next state FETCH.
//   FETCH : MEM_READ=1, MEM_ADDRESS=latched {tag,index}, BUSYWAIT=1.
//           MEM_BUSYWAIT=1 -> stay. MEM_BUSYWAIT=0 -> capture MEM_READDATA, -> UPDATE.
//   UPDATE: MEM_READ=0, BUSYWAIT=1; write data/tag, set valid at latched index; -> IDLE.
//  Back in IDLE the same PC now hits; BUSYWAIT falls combinationally that cycle.
//  Miss penalty: 1 (IDLE detect) + N (memory busy cycles) + 1 (FETCH accept) + 1 (UPDATE).
//  MEM_READ is high only in FETCH; MEM_ADDRESS holds stable for whole FETCH.
//  PC changes during FETCH/UPDATE (not expected; PC stalled) do not affect refill target.
//  Conflict miss simply overwrites line (no dirty state; read-only).
//  MEM_BUSYWAIT=0 on first FETCH cycle is legal: zero-wait refill, penalty 3 cycles.
//  MEM_BUSYWAIT ignored in IDLE/UPDATE.
//  PC bits [1:0] ignored; PC[31:10] ignored (aliasing accepted).
// TESTING
//  1 Reset then PC=0x000, memory busy 5 cycles -> BUSYWAIT=1 same cycle; MEM_READ=1,
//    MEM_ADDRESS=0 for 6 cycles; UPDATE; then BUSYWAIT=0, INSTRUCTION=block0[31:0].
//  2 After (1), PC=0x004,0x008,0x00C -> hits, BUSYWAIT=0, words 1..3 of block0, MEM_READ=0.
//  3 PC=0x010 -> miss, MEM_ADDRESS=6'd1; PC=0x080 (index 0, tag 1) -> MEM_ADDRESS=6'd8;
//    then PC=0x000 misses again (evicted), MEM_ADDRESS=0.
//  4 RESET asserted on 3rd FETCH cycle -> next cycle MEM_READ=0, state IDLE, BUSYWAIT=0;
//    after release PC=0x000 misses (valid cleared).
//  5 MEM_BUSYWAIT=0 throughout -> miss at PC=0x020 completes in 3 cycles, correct word.
//  6 PC=0x3FC then 0x400 (wraps to index0,tag0 via ignored bits) -> 0x400 hits block of 0x000 if valid.

Source files
------------

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: combinational hit path, 3-state refill FSM.
// Miss stalls the CPU via BUSYWAIT for 1 + N + 1 + 1 cycles while a 128-bit block is fetched.
module icache_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
  input  logic [127:0]          MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam int INDEX_BITS = $clog2(NUM_BLOCKS);
  localparam int TAG_BITS   = ADDR_WIDTH - 4 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

  state_t                      state;
  logic [NUM_BLOCKS-1:0]       valid;
  logic [TAG_BITS-1:0]         tag_array  [NUM_BLOCKS];
  logic [3:0][31:0]            data_array [NUM_BLOCKS];
  logic [127:0]                fill_buf;
  logic [TAG_BITS-1:0]         miss_tag;
  logic [INDEX_BITS-1:0]       miss_index;

  logic [INDEX_BITS-1:0]       pc_index;
  logic [TAG_BITS-1:0]         pc_tag;
  logic [1:0]                  pc_word;
  logic                        hit;
  logic                        unused_pc;

  assign pc_word  = PC[3:2];
  assign pc_index = PC[4 +: INDEX_BITS];
  assign pc_tag   = PC[4 + INDEX_BITS +: TAG_BITS];
  // Upper PC bits alias onto the same lines; byte offset is always zero for fetches.
  assign unused_pc = ^{PC[31:ADDR_WIDTH], PC[1:0]};

  assign hit         = valid[pc_index] && (tag_array[pc_index] == pc_tag);
  assign INSTRUCTION = data_array[pc_index][pc_word];

  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      case (state)
        IDLE:    BUSYWAIT = !hit;
        default: BUSYWAIT = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      valid       <= '0;
      MEM_READ    <= 1'b0;
      MEM_ADDRESS <= '0;
      miss_tag    <= '0;
      miss_index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            miss_tag    <= pc_tag;
            miss_index  <= pc_index;
            MEM_ADDRESS <= {pc_tag, pc_index};
            MEM_READ    <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          // Memory data is valid in the cycle its busy flag drops.
          if (!MEM_BUSYWAIT) begin
            fill_buf <= MEM_READDATA;
            MEM_READ <= 1'b0;
            state    <= UPDATE;
          end
        end
        UPDATE: begin
          data_array[miss_index] <= fill_buf;
          tag_array[miss_index]  <= miss_tag;
          valid[miss_index]      <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: driver pushes expected fetch results, monitor checks them.
module tb_icache_controller;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  icache_controller dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    int          stalls;
    logic [5:0]  addr;
    int          rdc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_pop = 0;
  int   mem_wait = 5;

  function automatic logic [31:0] mem_word(input logic [5:0] a, input logic [1:0] i);
    return {4'hC, i, 2'b00, 8'hA5, 2'b00, a, 8'h3C};
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] a);
    return {mem_word(a, 2'd3), mem_word(a, 2'd2), mem_word(a, 2'd1), mem_word(a, 2'd0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Instruction memory: busy for mem_wait cycles of each request, data only when not busy.
  int mem_cnt = 0;
  always @(posedge CLK) begin
    #1;
    if (MEM_READ) begin
      if (mem_cnt < mem_wait) begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = {4{32'hDEADBEEF}};
        mem_cnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = mem_block(MEM_ADDRESS);
      end
    end else begin
      mem_cnt      = 0;
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = {4{32'hDEADBEEF}};
    end
  end

  // Monitor: counts stall/read cycles, then checks the word when BUSYWAIT drops.
  int         mon_stall = 0;
  int         mon_rdc = 0;
  logic [5:0] mon_addr = '0;
  logic       mon_addr_bad = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      mon_stall    = 0;
      mon_rdc      = 0;
      mon_addr_bad = 1'b0;
    end else if (sb.size() > 0) begin
      if (BUSYWAIT) begin
        mon_stall++;
        if (MEM_READ) begin
          if (mon_rdc > 0 && MEM_ADDRESS !== mon_addr) mon_addr_bad = 1'b1;
          mon_addr = MEM_ADDRESS;
          mon_rdc++;
        end
      end else begin
        e = sb.pop_front();
        chk("instr", INSTRUCTION, e.instr);
        chk("stall_cycles", mon_stall, e.stalls);
        chk("mem_read_cycles", mon_rdc, e.rdc);
        if (e.stalls > 0) begin
          chk("mem_address", {26'd0, mon_addr}, {26'd0, e.addr});
          chk("addr_stable", {31'd0, mon_addr_bad}, 32'd0);
        end
        mon_stall    = 0;
        mon_rdc      = 0;
        mon_addr_bad = 1'b0;
        n_pop++;
      end
    end
  end

  // Presents pc now (just after a rising edge) and waits for the monitor to retire it.
  task automatic issue_now(input logic [31:0] pc, input int stalls, input logic [5:0] addr,
                           input int rdc);
    exp_t e;
    int   start;
    PC       = pc;
    e.instr  = mem_word(pc[9:4], pc[3:2]);
    e.stalls = stalls;
    e.addr   = addr;
    e.rdc    = rdc;
    start    = n_pop;
    sb.push_back(e);
    for (int k = 0; k < 100; k++) begin
      @(posedge CLK);
      if (n_pop != start) break;
    end
    if (n_pop == start) begin
      total++;
      bad++;
      $display("FAIL timeout pc=%h: no response within 100 cycles", pc);
      sb.delete();
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input int stalls, input logic [5:0] addr,
                       input int rdc);
    @(posedge CLK);
    #1;
    issue_now(pc, stalls, addr, rdc);
  endtask

  initial begin
    int nrd;
    RESET        = 1'b1;
    PC           = 32'h0;
    MEM_READDATA = '0;
    MEM_BUSYWAIT = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    chk("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    RESET = 1'b0;

    // Cold miss with 5 busy memory cycles, then the rest of block 0 hits.
    mem_wait = 5;
    issue_now(32'h000, 8, 6'd0, 6);
    fetch(32'h004, 0, 6'd0, 0);
    fetch(32'h008, 0, 6'd0, 0);
    fetch(32'h00C, 0, 6'd0, 0);

    // New index, conflict eviction of line 0, and re-miss on the evicted block.
    fetch(32'h010, 8, 6'd1, 6);
    fetch(32'h080, 8, 6'd8, 6);
    fetch(32'h000, 8, 6'd0, 6);

    // Zero-wait refill.
    mem_wait = 0;
    fetch(32'h020, 3, 6'd2, 1);
    fetch(32'h024, 0, 6'd0, 0);

    // Top of the lookup range, then an alias of 0x000 through ignored PC bits.
    fetch(32'h3FC, 3, 6'h3F, 1);
    fetch(32'h400, 0, 6'd0, 0);

    // Reset in the third FETCH cycle of a refill.
    mem_wait = 5;
    @(posedge CLK);
    #1;
    PC  = 32'h050;
    nrd = 0;
    for (int k = 0; k < 20 && nrd < 3; k++) begin
      @(negedge CLK);
      if (MEM_READ) nrd++;
    end
    chk("fetch_cycles_before_reset", nrd, 3);
    RESET = 1'b1;
    #1;
    chk("busywait_in_reset", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #1;
    chk("mid_refill_rst_mem_read", {31'd0, MEM_READ}, 32'd0);
    chk("mid_refill_rst_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
    chk("mid_refill_rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
    RESET = 1'b0;
    // Block 0 was resident before reset; it must miss now.
    issue_now(32'h000, 8, 6'd0, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
